ls_row_scheduler: RTL and testbench

//  Sequences generation of the per-block latin-square rows consumed by the AONT datapath.

---
 rtl/ls_row_scheduler_if.sv | 28 ++
 rtl/ls_row_scheduler.sv | 112 +++++++++++
 tb/tb_ls_row_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_row_scheduler_if.sv
// Row-scheduler handshake bundle: run control, captured first row and the emitted row stream.
// master = scheduler side, slave = consumer/controller side.
interface ls_row_scheduler_if #(
    parameter int unsigned LSLEN    = 16,
    parameter int unsigned LSLENLOG = 4
);
    logic                         start;
    logic                         abort;
    logic [LSLEN*LSLENLOG-1:0]    first_row;
    logic                         busy;
    logic                         row_valid;
    logic                         row_ready;
    logic [LSLENLOG-1:0]          row_idx;
    logic [LSLEN*LSLENLOG-1:0]    row_data;
    logic                         row_last;
    logic                         done;
    logic                         perm_err;

    modport master (
        input  start, abort, first_row, row_ready,
        output busy, row_valid, row_idx, row_data, row_last, done, perm_err
    );

    modport slave (
        output start, abort, first_row, row_ready,
        input  busy, row_valid, row_idx, row_data, row_last, done, perm_err
    );
endinterface

// File: rtl/ls_row_scheduler.sv
// Captures a latin-square first row, checks it is a permutation, then emits NBLOCKS rows
// where row k entry j = ((2k+1) * first[j]) mod LSLEN.
module ls_row_scheduler #(
    parameter int unsigned LSLEN    = 16,
    parameter int unsigned LSLENLOG = 4,
    parameter int unsigned NBLOCKS  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    ls_row_scheduler_if.master    io_sched
);
    localparam int unsigned RowW = LSLEN * LSLENLOG;
    localparam logic [LSLENLOG-1:0] KLast = LSLENLOG'(NBLOCKS - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StEmit, StDone} state_e;

    state_e              r_state, w_state_nxt;
    logic [LSLENLOG-1:0] r_k, w_k_nxt;
    logic [RowW-1:0]     r_row, w_row_nxt;
    logic                r_perm_err, w_perm_err_nxt;

    logic [LSLEN-1:0]    w_seen;
    logic                w_is_perm;
    logic [LSLENLOG:0]   w_mult;
    logic [LSLENLOG:0]   w_prod;
    logic [RowW-1:0]     w_data;
    logic                w_valid;

    // Permutation iff every value 0..LSLEN-1 is hit by some entry.
    always_comb begin
        w_seen = '0;
        for (int j = 0; j < int'(LSLEN); j++) begin
            w_seen = w_seen | (LSLEN'(1) << r_row[j*LSLENLOG +: LSLENLOG]);
        end
        w_is_perm = &w_seen;
    end

    // Odd multiplier 2k+1; low LSLENLOG bits of the product are the exact mod-LSLEN result.
    always_comb begin
        w_mult = {r_k, 1'b1};
        w_prod = '0;
        w_data = '0;
        for (int j = 0; j < int'(LSLEN); j++) begin
            w_prod = w_mult * {1'b0, r_row[j*LSLENLOG +: LSLENLOG]};
            w_data[j*LSLENLOG +: LSLENLOG] = w_prod[LSLENLOG-1:0];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_k_nxt        = r_k;
        w_row_nxt      = r_row;
        w_perm_err_nxt = r_perm_err;
        case (r_state)
            StIdle: begin
                if (io_sched.start) begin
                    w_row_nxt      = io_sched.first_row;
                    w_perm_err_nxt = 1'b0;
                    w_k_nxt        = '0;
                    w_state_nxt    = StCheck;
                end
            end
            StCheck: begin
                if (io_sched.abort) begin
                    w_state_nxt = StIdle;
                end else if (!w_is_perm) begin
                    w_perm_err_nxt = 1'b1;
                    w_state_nxt    = StDone;
                end else begin
                    w_state_nxt = StEmit;
                end
            end
            StEmit: begin
                // Abort beats a same-cycle handshake: the row is not counted as transferred.
                if (io_sched.abort) begin
                    w_state_nxt = StIdle;
                end else if (io_sched.row_ready) begin
                    if (r_k == KLast) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_k_nxt = r_k + LSLENLOG'(1);
                    end
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state    <= StIdle;
            r_k        <= '0;
            r_row      <= '0;
            r_perm_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_row      <= w_row_nxt;
            r_perm_err <= w_perm_err_nxt;
        end
    end

    assign w_valid            = (r_state == StEmit);
    assign io_sched.busy      = (r_state != StIdle);
    assign io_sched.row_valid = w_valid;
    assign io_sched.row_idx   = w_valid ? r_k : '0;
    assign io_sched.row_data  = w_valid ? w_data : '0;
    assign io_sched.row_last  = w_valid && (r_k == KLast);
    assign io_sched.done      = (r_state == StDone);
    assign io_sched.perm_err  = r_perm_err;
endmodule

// File: tb/tb_ls_row_scheduler.sv
// Bench for ls_row_scheduler: arithmetic reference model checked every cycle plus literal
// row/latency expectations for identity, non-permutation, backpressure, abort, reset and start-hold.
module tb_ls_row_scheduler;
    localparam int unsigned LSLEN    = 16;
    localparam int unsigned LSLENLOG = 4;
    localparam int unsigned NBLOCKS  = 8;

    localparam logic [63:0] IDENT = 64'hFEDCBA9876543210;
    localparam logic [63:0] ROW1  = 64'hDA741EB852FC9630;
    localparam logic [63:0] ROW7  = 64'h123456789ABCDEF0;
    localparam logic [63:0] FIVES = 64'h5555555555555555;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    ls_row_scheduler_if #(.LSLEN(LSLEN), .LSLENLOG(LSLENLOG)) bus ();

    ls_row_scheduler #(.LSLEN(LSLEN), .LSLENLOG(LSLENLOG), .NBLOCKS(NBLOCKS)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .io_sched (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 checking, 2 emitting, 3 finishing.
    int m_mode = 0;
    int m_k    = 0;
    int m_cap[LSLEN];
    bit m_perr = 1'b0;
    int m_xfers[$];
    int d_xfers[$];

    function automatic bit perm_ok();
        int cnt[LSLEN];
        for (int v = 0; v < int'(LSLEN); v++) cnt[v] = 0;
        for (int j = 0; j < int'(LSLEN); j++) cnt[m_cap[j]]++;
        for (int v = 0; v < int'(LSLEN); v++) if (cnt[v] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] exp_data();
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < int'(LSLEN); j++) r[j*4 +: 4] = 4'(((2 * m_k + 1) * m_cap[j]) % LSLEN);
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rstn && bus.row_valid === 1'b1 && bus.row_ready && !bus.abort)
            d_xfers.push_back(int'(bus.row_idx));
        if (rstn) begin
            m_mode = 0;
            m_k    = 0;
            m_perr = 1'b0;
            for (int j = 0; j < int'(LSLEN); j++) m_cap[j] = 0;
        end else begin
            case (m_mode)
                0: if (bus.start) begin
                    for (int j = 0; j < int'(LSLEN); j++) m_cap[j] = int'(bus.first_row[j*4 +: 4]);
                    m_perr = 1'b0;
                    m_k    = 0;
                    m_mode = 1;
                end
                1: begin
                    if (bus.abort) m_mode = 0;
                    else if (!perm_ok()) begin
                        m_perr = 1'b1;
                        m_mode = 3;
                    end else m_mode = 2;
                end
                2: begin
                    if (bus.abort) m_mode = 0;
                    else if (bus.row_ready) begin
                        m_xfers.push_back(m_k);
                        if (m_k == int'(NBLOCKS) - 1) m_mode = 3;
                        else m_k++;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    logic m_v;
    always @(negedge clk) begin
        if (chk_en) begin
            m_v = (m_mode == 2);
            check("busy",      bus.busy,      m_mode != 0);
            check("row_valid", bus.row_valid, m_v);
            check("row_idx",   bus.row_idx,   m_v ? m_k : 0);
            check("row_data",  bus.row_data,  m_v ? exp_data() : 64'd0);
            check("row_last",  bus.row_last,  m_v && (m_k == int'(NBLOCKS) - 1));
            check("done",      bus.done,      m_mode == 3);
            check("perm_err",  bus.perm_err,  m_perr);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [63:0] row);
        bus.first_row = row;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            step();
        end
        check({name, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic cmp_xfers(input string name, input int n);
        check({name, "_dut_count"}, d_xfers.size(), n);
        check({name, "_model_count"}, m_xfers.size(), n);
        for (int i = 0; i < d_xfers.size(); i++) check({name, "_idx"}, d_xfers[i], i);
        m_xfers.delete();
        d_xfers.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    int dones;
    logic [3:0] pat;

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.row_ready = 1'b1;
        bus.first_row = IDENT;
        step();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_data", bus.row_data, 64'd0);
        check("rst_perm", bus.perm_err, 1'b0);
        chk_en = 1'b1;
        rstn   = 1'b0;
        step();

        // 1: identity row, ready held high; first_row scrambled after capture
        pulse_start(IDENT);
        bus.first_row = FIVES;
        check("t1_check_valid", bus.row_valid, 1'b0);
        step();
        check("t1_row0", bus.row_data, IDENT);
        step();
        check("t1_row1", bus.row_data, ROW1);
        repeat (6) step();
        check("t1_row7", bus.row_data, ROW7);
        check("t1_last", bus.row_last, 1'b1);
        step();
        check("t1_done", bus.done, 1'b1);
        step();
        check("t1_idle", bus.busy, 1'b0);
        cmp_xfers("t1", 8);

        // 2: non-permutation, then recovery
        pulse_start(FIVES);
        step();
        check("t2_done", bus.done, 1'b1);
        check("t2_perm", bus.perm_err, 1'b1);
        repeat (3) step();
        check("t2_sticky", bus.perm_err, 1'b1);
        pulse_start(IDENT);
        check("t2_clear", bus.perm_err, 1'b0);
        wait_idle("t2");
        cmp_xfers("t2", 8);

        // 3: backpressure 1,0,0,1
        pat = 4'b1001;
        pulse_start(IDENT);
        for (int i = 0; i < 200 && bus.busy; i++) begin
            bus.row_ready = pat[i % 4];
            step();
        end
        bus.row_ready = 1'b1;
        check("t3_idle", bus.busy, 1'b0);
        cmp_xfers("t3", 8);

        // 4: abort at k=3 with a same-cycle handshake
        pulse_start(IDENT);
        repeat (4) step();
        check("t4_at_k3", bus.row_idx, 4'd3);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4_busy", bus.busy, 1'b0);
        check("t4_done", bus.done, 1'b0);
        repeat (2) step();
        cmp_xfers("t4", 3);

        // 5: reset mid-emit at k=5
        pulse_start(IDENT);
        repeat (6) step();
        check("t5_at_k5", bus.row_idx, 4'd5);
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_valid", bus.row_valid, 1'b0);
        check("t5_data", bus.row_data, 64'd0);
        pulse_start(IDENT);
        step();
        check("t5_row0", bus.row_data, IDENT);
        wait_idle("t5");
        m_xfers.delete();
        d_xfers.delete();

        // 6: start held high across the done cycle
        dones = 0;
        bus.first_row = IDENT;
        bus.start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (bus.done) dones++;
        end
        check("t6_idle_after", bus.busy, 1'b0);
        bus.start = 1'b0;
        check("t6_one_done", dones, 1);
        repeat (2) step();
        check("t6_still_idle", bus.busy, 1'b0);
        pulse_start(IDENT);
        step();
        check("t6_rerun_row0", bus.row_idx, 4'd0);
        check("t6_rerun_valid", bus.row_valid, 1'b1);
        wait_idle("t6");
        check("t6_xfers", d_xfers.size(), 16);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
